// File: rtl/ble_pkg.sv
// Shared types and constants for the BLE link-layer transmitter and its CRC helper.
package ble_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_AA,
    S_HEADER,
    S_PAYLOAD,
    S_CRC
  } tx_state_e;

  localparam logic [23:0] BLE_CRC_POLY   = 24'h00065B;
  localparam logic [7:0]  BLE_PREAMBLE_0 = 8'hAA;
  localparam logic [7:0]  BLE_PREAMBLE_1 = 8'h55;

  localparam int LEN_PREAMBLE = 8;
  localparam int LEN_AA       = 32;
  localparam int LEN_HEADER   = 16;
  localparam int LEN_BYTE     = 8;
  localparam int LEN_CRC      = 24;

  // Index of the final bit of the field sent in state s.
  function automatic logic [4:0] field_last_idx(input tx_state_e s);
    case (s)
      S_PREAMBLE: return 5'(LEN_PREAMBLE - 1);
      S_AA:       return 5'(LEN_AA - 1);
      S_HEADER:   return 5'(LEN_HEADER - 1);
      S_PAYLOAD:  return 5'(LEN_BYTE - 1);
      S_CRC:      return 5'(LEN_CRC - 1);
      default:    return 5'd0;
    endcase
  endfunction

  function automatic logic [23:0] rev24(input logic [23:0] v);
    logic [23:0] r;
    for (int i = 0; i < 24; i++) r[i] = v[23-i];
    return r;
  endfunction

endpackage

// File: rtl/ble_crc24_serial.sv
// Bit-serial BLE CRC24 (poly 0x00065B); one input bit per enabled clock.
module ble_crc24_serial
  import ble_pkg::*;
#(
  parameter logic [23:0] CRC_INIT = 24'h555555
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic        bit_in,
  output logic [23:0] crc_out
);

  logic [23:0] r_crc;
  logic        w_fb;

  assign w_fb    = r_crc[23] ^ bit_in;
  assign crc_out = r_crc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_crc <= CRC_INIT;
    else if (init) r_crc <= CRC_INIT;
    else if (en)   r_crc <= {r_crc[22:0], 1'b0} ^ (w_fb ? BLE_CRC_POLY : 24'd0);
  end

endmodule

// File: rtl/ble_packet_tx.sv
// BLE 1M packet serialiser: preamble, AA, header, payload, CRC24, LSB first.
// Optional data whitening when BLE_TX_WHITEN_EN is defined.
module ble_packet_tx
  import ble_pkg::*;
#(
  parameter int          CLK_PER_BIT = 100,
  parameter logic [23:0] CRC_INIT    = 24'h555555,
  parameter int          MAX_PAYLOAD = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] access_addr,
  input  logic [15:0] pdu_header,
  input  logic [5:0]  chan_idx,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic        tx_bit,
  output logic        tx_bit_strobe,
  output logic        tx_active,
  output logic        tx_done,
  output logic        underrun,
  output tx_state_e   dbg_state
);

  localparam int            CW          = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] LP_CNT_LAST = CW'(CLK_PER_BIT - 1);

  // Byte handshake: pl_ready is a single-cycle offer; the byte is taken iff pl_valid is high
  // in that same cycle, otherwise the packet is aborted with an underrun pulse.
  tx_state_e     r_state, w_next_state;
  logic [CW-1:0] r_cnt;
  logic [4:0]    r_idx, w_next_idx;
  logic [31:0]   r_shift, w_next_shift, r_aa;
  logic [15:0]   r_hdr;
  logic [7:0]    r_len_left, r_pl_byte, w_byte, w_preamble;
  logic          r_bit, r_strobe, r_done, r_underrun;
  logic          w_field_last, w_boundary, w_pl_ready, w_load, w_raw, w_tx_bit;
  logic          w_whiten, w_crc_en, w_crc_init, w_finish, w_abort, w_load_byte;
  logic [23:0]   w_crc, w_crc_rev;

  assign w_field_last = (r_idx == field_last_idx(r_state));
  assign w_boundary   = (r_state != S_IDLE) && (r_cnt == LP_CNT_LAST);
  assign w_pl_ready   = (r_state == S_HEADER || r_state == S_PAYLOAD) && w_field_last &&
                        (r_len_left != 8'd0) && (r_cnt == CW'(1));
  // With CLK_PER_BIT=2 the offer cycle is also the bit boundary, so bypass the holding reg.
  assign w_byte       = w_pl_ready ? pl_data : r_pl_byte;
  assign w_preamble   = access_addr[0] ? BLE_PREAMBLE_1 : BLE_PREAMBLE_0;
  assign w_crc_rev    = rev24(w_crc);
  assign w_crc_init   = (r_state == S_IDLE) && start;

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_raw        = 1'b0;
    w_next_shift = r_shift;
    w_next_idx   = r_idx;
    w_whiten     = 1'b0;
    w_crc_en     = 1'b0;
    w_finish     = 1'b0;
    w_abort      = 1'b0;
    w_load_byte  = 1'b0;
    if (r_state == S_IDLE) begin
      if (start) begin
        w_next_state = S_PREAMBLE;
        w_load       = 1'b1;
        w_raw        = w_preamble[0];
        w_next_shift = {24'd0, w_preamble} >> 1;
        w_next_idx   = 5'd0;
      end
    end else if (w_pl_ready && !pl_valid) begin
      w_abort      = 1'b1;
      w_next_state = S_IDLE;
    end else if (w_boundary) begin
      w_load       = 1'b1;
      w_raw        = r_shift[0];
      w_next_shift = r_shift >> 1;
      w_next_idx   = w_field_last ? 5'd0 : r_idx + 5'd1;
      w_whiten     = (r_state == S_HEADER) || (r_state == S_PAYLOAD) || (r_state == S_CRC);
      w_crc_en     = (r_state == S_HEADER) || (r_state == S_PAYLOAD);
      if (w_field_last) begin
        case (r_state)
          S_PREAMBLE: begin
            w_next_state = S_AA;
            w_raw        = r_aa[0];
            w_next_shift = r_aa >> 1;
            w_whiten     = 1'b0;
            w_crc_en     = 1'b0;
          end
          S_AA: begin
            w_next_state = S_HEADER;
            w_raw        = r_hdr[0];
            w_next_shift = {16'd0, r_hdr} >> 1;
            w_whiten     = 1'b1;
            w_crc_en     = 1'b1;
          end
          S_HEADER, S_PAYLOAD: begin
            w_whiten = 1'b1;
            if (r_len_left != 8'd0) begin
              w_next_state = S_PAYLOAD;
              w_raw        = w_byte[0];
              w_next_shift = {24'd0, w_byte} >> 1;
              w_crc_en     = 1'b1;
              w_load_byte  = 1'b1;
            end else begin
              w_next_state = S_CRC;
              w_raw        = w_crc_rev[0];
              w_next_shift = {8'd0, w_crc_rev} >> 1;
              w_crc_en     = 1'b0;
            end
          end
          default: begin
            // Last CRC bit period has ended.
            w_load       = 1'b0;
            w_whiten     = 1'b0;
            w_finish     = 1'b1;
            w_next_state = S_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_aa       <= '0;
      r_hdr      <= '0;
      r_len_left <= '0;
      r_pl_byte  <= '0;
      r_bit      <= 1'b0;
      r_strobe   <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_strobe   <= w_load;
      r_done     <= w_finish;
      r_underrun <= w_abort;
      if (w_load) begin
        r_bit   <= w_tx_bit;
        r_shift <= w_next_shift;
        r_idx   <= w_next_idx;
        r_cnt   <= '0;
      end else if (w_finish || w_abort) begin
        r_bit <= 1'b0;
        r_idx <= '0;
        r_cnt <= '0;
      end else if (r_state != S_IDLE) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_crc_init) begin
        r_aa       <= access_addr;
        r_hdr      <= pdu_header;
        r_len_left <= (int'(pdu_header[15:8]) > MAX_PAYLOAD) ? 8'(MAX_PAYLOAD) : pdu_header[15:8];
      end else if (w_load_byte) begin
        r_len_left <= r_len_left - 8'd1;
      end
      if (w_pl_ready && pl_valid) r_pl_byte <= pl_data;
    end
  end

  ble_crc24_serial #(.CRC_INIT(CRC_INIT)) u_crc (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (w_crc_init),
    .en      (w_load && w_crc_en),
    .bit_in  (w_raw),
    .crc_out (w_crc)
  );

`ifdef BLE_TX_WHITEN_EN
  logic [6:0] r_w;
  assign w_tx_bit = w_raw ^ (w_whiten & r_w[6]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_w <= '1;
    else if (w_crc_init)         r_w <= {chan_idx[0], chan_idx[1], chan_idx[2], chan_idx[3],
                                         chan_idx[4], chan_idx[5], 1'b1};
    else if (w_load && w_whiten) r_w <= {r_w[5:4], r_w[3] ^ r_w[6], r_w[2:0], r_w[6]};
  end
`else
  logic w_unused_chan;
  assign w_unused_chan = ^{chan_idx, w_whiten};
  assign w_tx_bit      = w_raw;
`endif

  assign pl_ready      = w_pl_ready;
  assign tx_bit        = r_bit;
  assign tx_bit_strobe = r_strobe;
  assign tx_active     = (r_state != S_IDLE);
  assign tx_done       = r_done;
  assign underrun      = r_underrun;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_ble_packet_tx.sv
// Self-checking bench for ble_packet_tx: vector table, corner sequences, random packets vs golden model.
module tb_ble_packet_tx;

  localparam int          CPB        = 4;
  localparam int          MAX_PL     = 6;
  localparam logic [23:0] CRC_PRESET = 24'h555555;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] access_addr = '0;
  logic [15:0] pdu_header = '0;
  logic [5:0]  chan_idx = '0;
  logic [7:0]  pl_data = '0;
  logic        pl_valid = 1'b0;
  logic        pl_ready, tx_bit, tx_bit_strobe, tx_active, tx_done, underrun;
  ble_pkg::tx_state_e dbg_state;

  int total = 0;
  int bad = 0;
  logic [0:0] exp_q[$];
  logic [7:0] pl_bytes[256];

  typedef struct {
    logic [31:0] aa;
    logic [15:0] hdr;
    logic [5:0]  ch;
    int          drop;      // pl_ready index answered with pl_valid=0, -1 for none
    int          inj;       // cycle of a stray start during the packet, 0 for none
    logic [7:0]  exp_first8;
    int          exp_bits;
    int          exp_ready;
  } vec_t;

  vec_t vecs[7];

  // clock / reset
  always #5 clk = ~clk;

  ble_packet_tx #(
    .CLK_PER_BIT (CPB),
    .CRC_INIT    (CRC_PRESET),
    .MAX_PAYLOAD (MAX_PL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .access_addr   (access_addr),
    .pdu_header    (pdu_header),
    .chan_idx      (chan_idx),
    .pl_data       (pl_data),
    .pl_valid      (pl_valid),
    .pl_ready      (pl_ready),
    .tx_bit        (tx_bit),
    .tx_bit_strobe (tx_bit_strobe),
    .tx_active     (tx_active),
    .tx_done       (tx_done),
    .underrun      (underrun),
    .dbg_state     (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Golden on-air bit stream built from the packet format rules.
  function automatic void build_expected(input logic [31:0] aa, input logic [15:0] hdr,
                                         input logic [5:0] ch, input int n_pl);
    logic       body[$];
    logic [7:0] pre;
    logic [23:0] crc;
    logic [6:0] w;
    exp_q.delete();
    pre = aa[0] ? 8'h55 : 8'hAA;
    for (int i = 0; i < 8; i++) exp_q.push_back(pre[i]);
    for (int i = 0; i < 32; i++) exp_q.push_back(aa[i]);
    for (int i = 0; i < 16; i++) body.push_back(hdr[i]);
    for (int b = 0; b < n_pl; b++)
      for (int i = 0; i < 8; i++) body.push_back(pl_bytes[b][i]);
    crc = CRC_PRESET;
    foreach (body[k]) crc = {crc[22:0], 1'b0} ^ ((crc[23] ^ body[k]) ? 24'h00065B : 24'h0);
    for (int i = 0; i < 24; i++) body.push_back(crc[23-i]);
    w = {ch[0], ch[1], ch[2], ch[3], ch[4], ch[5], 1'b1};
    foreach (body[k]) begin
`ifdef BLE_TX_WHITEN_EN
      body[k] = body[k] ^ w[6];
      w = {w[5:4], w[3] ^ w[6], w[2:0], w[6]};
`endif
      exp_q.push_back(body[k]);
    end
  endfunction

  // Driver + monitor for one packet; all sampling and driving happens on the falling edge.
  task automatic run_pkt(input vec_t v);
    int n_pl, cyc, budget, n_bits, n_ready, last_strobe, ready_cyc, done_cyc, und_cyc;
    int act_err, late_done;
    logic [7:0] first8;
    logic [0:0] e;
    logic end_act, end_bit;
    n_pl = (int'(v.hdr[15:8]) > MAX_PL) ? MAX_PL : int'(v.hdr[15:8]);
    build_expected(v.aa, v.hdr, v.ch, n_pl);
    budget = (80 + 8 * n_pl) * CPB + 40;
    cyc = 0; n_bits = 0; n_ready = 0; last_strobe = 0; ready_cyc = -1;
    done_cyc = -1; und_cyc = -1; act_err = 0; first8 = '0; end_act = 1'b1; end_bit = 1'b1;
    @(negedge clk);
    access_addr = v.aa;
    pdu_header  = v.hdr;
    chan_idx    = v.ch;
    start       = 1'b1;
    while (done_cyc < 0 && und_cyc < 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start = (cyc == v.inj);
      if (tx_bit_strobe) begin
        if (n_bits == 0) check("first_strobe_cycle", cyc, 1);
        else             check("bit_spacing", cyc - last_strobe, CPB);
        if (n_bits < 8) first8[n_bits[2:0]] = tx_bit;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("bit", tx_bit, e);
        end
        last_strobe = cyc;
        n_bits++;
      end
      if (pl_ready) begin
        ready_cyc = cyc;
        pl_valid  = (n_ready != v.drop);
        pl_data   = pl_bytes[n_ready];
        n_ready++;
      end else begin
        pl_valid = 1'b1;
        pl_data  = 8'h00;
      end
      if (tx_done) begin
        done_cyc = cyc; end_act = tx_active; end_bit = tx_bit;
      end else if (underrun) begin
        und_cyc = cyc; end_act = tx_active;
      end else if (!tx_active) begin
        act_err++;
      end
    end
    start    = 1'b0;
    pl_valid = 1'b0;
    check("bits_sent", n_bits, v.exp_bits);
    check("first8", first8, v.exp_first8);
    check("ready_pulses", n_ready, v.exp_ready);
    check("active_gap", act_err, 0);
    if (v.drop < 0) begin
      check("done_seen", done_cyc >= 0, 1);
      if (done_cyc >= 0) begin
        check("done_latency", done_cyc - last_strobe, CPB);
        check("done_active", end_act, 0);
        check("done_bit", end_bit, 0);
      end
      check("exp_left", exp_q.size(), 0);
    end else begin
      check("underrun_seen", und_cyc >= 0, 1);
      if (und_cyc >= 0) begin
        check("underrun_latency", und_cyc - ready_cyc, 1);
        check("abort_active", end_act, 0);
      end
      late_done = 0;
      repeat (3 * CPB) begin
        @(negedge clk);
        if (tx_done || tx_active) late_done++;
      end
      check("quiet_after_underrun", late_done, 0);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int nr, cnt, len, drop;
    vec_t rv;
    for (int i = 0; i < 256; i++) pl_bytes[i] = 8'(17 * (i + 1));

    vecs[0] = '{32'h8E89BED6, 16'h0000, 6'd37, -1, 0,  8'hAA, 80,  0};
    vecs[1] = '{32'h8E89BED7, 16'h0000, 6'd37, -1, 0,  8'h55, 80,  0};
    vecs[2] = '{32'h8E89BED6, 16'h0302, 6'd37, -1, 0,  8'hAA, 104, 3};
    vecs[3] = '{32'h8E89BED6, 16'h0302, 6'd37, 1,  0,  8'hAA, 64,  2};
    vecs[4] = '{32'h8E89BED6, 16'h0302, 6'd5,  -1, 20, 8'hAA, 104, 3};
    vecs[5] = '{32'hA5A5A5A5, 16'h0225, 6'd12, -1, 0,  8'h55, 96,  2};
    vecs[6] = '{32'h8E89BED6, 16'h0801, 6'd37, -1, 0,  8'hAA, 128, 6};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {pl_ready, tx_bit, tx_bit_strobe, tx_active, tx_done, underrun}, 0);
    check("reset_state", dbg_state, ble_pkg::S_IDLE);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_pkt(vecs[i]);

    // Reset in the middle of the payload.
    @(negedge clk);
    access_addr = 32'h8E89BED6; pdu_header = 16'h0302; chan_idx = 6'd37; start = 1'b1;
    pl_valid = 1'b1;
    nr = 0; cnt = 0;
    @(negedge clk);
    start = 1'b0;
    while (nr < 2 && cnt < 600) begin
      if (pl_ready) nr++;
      @(negedge clk);
      cnt++;
    end
    check("payload_reached", nr, 2);
    repeat (2) @(negedge clk);
    check("active_before_reset", tx_active, 1);
    rst_n = 1'b0;
    #1;
    check("reset_mid_outputs", {pl_ready, tx_bit, tx_bit_strobe, tx_active, tx_done, underrun}, 0);
    @(negedge clk);
    check("reset_mid_no_done", {tx_done, underrun}, 0);
    rst_n = 1'b1;
    pl_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Randomised packets.
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(0, 5);
      for (int b = 0; b < 8; b++) pl_bytes[b] = 8'($urandom);
      drop = ($urandom_range(0, 3) == 0 && len > 0) ? $urandom_range(0, len - 1) : -1;
      rv.aa        = $urandom;
      rv.hdr       = {8'(len), 8'($urandom)};
      rv.ch        = 6'($urandom_range(0, 39));
      rv.drop      = drop;
      rv.inj       = 0;
      rv.exp_first8 = rv.aa[0] ? 8'h55 : 8'hAA;
      rv.exp_bits  = (drop < 0) ? 80 + 8 * len : 56 + 8 * drop;
      rv.exp_ready = (drop < 0) ? len : drop + 1;
      run_pkt(rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
